// File: rtl/mdu_if.sv
// Handshake/data bundle between the E-stage pipeline and the multiply/divide unit.
// The pipeline side uses the master modport; the MDU uses the slave modport.
interface mdu_if;
    logic        req;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] out;

    modport master (
        output req, start, op, a, b,
        input  busy, hi, lo, out
    );

    modport slave (
        input  req, start, op, a, b,
        output busy, hi, lo, out
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; result is computed at accept
// and committed to HI/LO after a fixed busy window.
//
// state | meaning
// IDLE  | counter is zero, not busy; accepts start, mthi/mtlo
// RUN   | counter counting down; HI/LO commit on the cnt==1 edge
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_temp_hi;
    logic [31:0]        r_temp_lo;
    logic               r_div_zero;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]        w_hi_nxt;
    logic [31:0]        w_lo_nxt;
    logic [31:0]        w_temp_hi_nxt;
    logic [31:0]        w_temp_lo_nxt;
    logic               w_div_zero_nxt;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_accept;
    logic               w_mt_ok;

    logic [63:0]        w_mul_a;
    logic [63:0]        w_mul_b;
    logic [63:0]        w_prod;

    logic               w_neg_a;
    logic               w_neg_b;
    logic [31:0]        w_mag_a;
    logic [31:0]        w_mag_b;
    logic [31:0]        w_divisor;
    logic [31:0]        w_mag_q;
    logic [31:0]        w_mag_r;
    logic [31:0]        w_quot;
    logic [31:0]        w_rem;

    assign w_is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign w_is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign w_accept = bus.start && !bus.req && (r_state == IDLE) && (w_is_mul || w_is_div);
    assign w_mt_ok  = !bus.req && (r_state == IDLE);

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign w_mul_a = (bus.op == OP_MULT) ? {{32{bus.a[31]}}, bus.a} : {32'd0, bus.a};
    assign w_mul_b = (bus.op == OP_MULT) ? {{32{bus.b[31]}}, bus.b} : {32'd0, bus.b};
    assign w_prod  = w_mul_a * w_mul_b;

    // Signed divide on magnitudes: 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_neg_a   = (bus.op == OP_DIV) && bus.a[31];
    assign w_neg_b   = (bus.op == OP_DIV) && bus.b[31];
    assign w_mag_a   = w_neg_a ? (32'd0 - bus.a) : bus.a;
    assign w_mag_b   = w_neg_b ? (32'd0 - bus.b) : bus.b;
    assign w_divisor = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_mag_q   = w_mag_a / w_divisor;
    assign w_mag_r   = w_mag_a % w_divisor;
    assign w_quot    = (w_neg_a ^ w_neg_b) ? (32'd0 - w_mag_q) : w_mag_q;
    assign w_rem     = w_neg_a ? (32'd0 - w_mag_r) : w_mag_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_temp_hi  <= 32'd0;
            r_temp_lo  <= 32'd0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hi       <= w_hi_nxt;
            r_lo       <= w_lo_nxt;
            r_temp_hi  <= w_temp_hi_nxt;
            r_temp_lo  <= w_temp_lo_nxt;
            r_div_zero <= w_div_zero_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hi_nxt       = r_hi;
        w_lo_nxt       = r_lo;
        w_temp_hi_nxt  = r_temp_hi;
        w_temp_lo_nxt  = r_temp_lo;
        w_div_zero_nxt = r_div_zero;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                    if (w_is_mul) begin
                        w_cnt_nxt      = CNT_W'(MULT_CYCLES);
                        w_temp_hi_nxt  = w_prod[63:32];
                        w_temp_lo_nxt  = w_prod[31:0];
                        w_div_zero_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt      = CNT_W'(DIV_CYCLES);
                        w_temp_hi_nxt  = w_rem;
                        w_temp_lo_nxt  = w_quot;
                        w_div_zero_nxt = (bus.b == 32'd0);
                    end
                end else if (w_mt_ok && (bus.op == OP_MTHI)) begin
                    w_hi_nxt = bus.a;
                end else if (w_mt_ok && (bus.op == OP_MTLO)) begin
                    w_lo_nxt = bus.a;
                end
            end
            RUN: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    // A zero divisor still occupies the unit but leaves HI/LO alone.
                    if (!r_div_zero) begin
                        w_hi_nxt = r_temp_hi;
                        w_lo_nxt = r_temp_lo;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_MFHI: bus.out = r_hi;
            OP_MFLO: bus.out = r_lo;
            default: bus.out = 32'd0;
        endcase
    end

    assign bus.busy = (r_cnt != '0);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
